// File: rtl/aes_chain_fsm.sv
// ---------------------------------------------------------------------------
// aes_chain_fsm
// Block-chaining controller that sits between a word-wide input stream, a
// block-wide cipher core and a word-wide output stream. A job of data_size_i
// bytes is split into BLOCK_W-bit blocks. Each block is collected MSB-word
// first, handed to the core, and the result is streamed out MSB-word first.
// ECB passes blocks straight through. CBC encrypt XORs the chain into the
// core input. CBC decrypt XORs the chain into the core output.
//
// Ports
//   clk_i, rst_i          clock, async active-high reset
//   clear_i               synchronous soft clear (abandons the job)
//   start_i, cbc_i, encrypt_i, data_size_i, iv_i   job request + config
//   core_*                cipher core start/block and done/result
//   in_valid_i/in_ready_o/in_data_i     input word stream
//   out_valid_o/out_ready_i/out_data_o  output word stream
//   busy_o, done_o, size_err_o, blocks_done_o      status
// ---------------------------------------------------------------------------
module aes_chain_fsm #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic               cbc_i,
    input  logic               encrypt_i,
    input  logic [31:0]        data_size_i,
    input  logic [BLOCK_W-1:0] iv_i,
    input  logic               core_ready_i,
    output logic               core_start_o,
    output logic [BLOCK_W-1:0] core_block_o,
    input  logic               core_done_i,
    input  logic [BLOCK_W-1:0] core_result_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               size_err_o,
    output logic [CNT_W-1:0]   blocks_done_o
);

    localparam int          WORDS = BLOCK_W / DATA_W;
    localparam int          WC_W  = $clog2(WORDS) + 1;
    localparam logic [31:0] BYTES = 32'(BLOCK_W / 8);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, CORE_START, CORE_WAIT, SEND, FINISHED
    } state_t;

    state_t             state_q, state_d;
    logic               cbc_q, cbc_d;
    logic               enc_q, enc_d;
    logic [31:0]        rem_q, rem_d;      // blocks still to emit this job
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;      // assembled input block
    logic [BLOCK_W-1:0] res_q, res_d;      // output block, shifted out MSB first
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   bdone_q, bdone_d;
    logic               size_err_q, size_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cbc_q      <= 1'b0;
            enc_q      <= 1'b0;
            rem_q      <= '0;
            chain_q    <= '0;
            blk_q      <= '0;
            res_q      <= '0;
            wcnt_q     <= '0;
            bdone_q    <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cbc_q      <= cbc_d;
            enc_q      <= enc_d;
            rem_q      <= rem_d;
            chain_q    <= chain_d;
            blk_q      <= blk_d;
            res_q      <= res_d;
            wcnt_q     <= wcnt_d;
            bdone_q    <= bdone_d;
            size_err_q <= size_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cbc_d      = cbc_q;
        enc_d      = enc_q;
        rem_d      = rem_q;
        chain_d    = chain_q;
        blk_d      = blk_q;
        res_d      = res_q;
        wcnt_d     = wcnt_q;
        bdone_d    = bdone_q;
        size_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cbc_d   = cbc_i;
                    enc_d   = encrypt_i;
                    chain_d = iv_i;
                    if ((data_size_i % BYTES) != 32'd0) begin
                        size_err_d = 1'b1;
                    end else begin
                        rem_d   = data_size_i / BYTES;
                        wcnt_d  = '0;
                        bdone_d = '0;
                        state_d = (data_size_i == 32'd0) ? FINISHED : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (in_valid_i) begin
                    // shift left so the first word ends up in the MSBs
                    blk_d = (blk_q << DATA_W) | BLOCK_W'(in_data_i);
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        state_d = CORE_START;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            CORE_START: begin
                if (core_ready_i) state_d = CORE_WAIT;
            end
            CORE_WAIT: begin
                if (core_done_i) begin
                    res_d = (cbc_q && !enc_q) ? (core_result_i ^ chain_q) : core_result_i;
                    // encrypt chains on ciphertext out, decrypt on ciphertext in
                    if (cbc_q) chain_d = enc_q ? core_result_i : blk_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    res_d = res_q << DATA_W;
                    if (wcnt_q == LAST_WORD) begin
                        wcnt_d  = '0;
                        bdone_d = bdone_q + 1'b1;
                        rem_d   = rem_q - 32'd1;
                        state_d = (rem_q == 32'd1) ? FINISHED : COLLECT;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            FINISHED: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            cbc_d      = 1'b0;
            enc_d      = 1'b0;
            rem_d      = '0;
            chain_d    = '0;
            blk_d      = '0;
            res_d      = '0;
            wcnt_d     = '0;
            bdone_d    = '0;
            size_err_d = 1'b0;
        end
    end

    // blk_q and chain_q do not move between CORE_START and the capture edge,
    // so the core input is stable for the whole core transaction.
    assign core_block_o  = (cbc_q && enc_q) ? (blk_q ^ chain_q) : blk_q;
    assign core_start_o  = (state_q == CORE_START) && core_ready_i;
    assign in_ready_o    = (state_q == COLLECT);
    assign out_valid_o   = (state_q == SEND);
    assign out_data_o    = res_q[BLOCK_W-1 -: DATA_W];
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == FINISHED);
    assign size_err_o    = size_err_q;
    assign blocks_done_o = bdone_q;

endmodule
